// File: rtl/alu_divider_seq.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish in one cycle.
module alu_divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             FLUSH,
  input  logic [5:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_reg;
  logic             op_rem_reg;
  logic             op_signed_reg;
  logic             neg1_reg;
  logic             neg2_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] result_reg;

  logic             valid_sel;
  logic             accept;
  logic             sel_signed;
  logic             sel_rem;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             fast;
  logic [WIDTH-1:0] fast_val;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             trial_neg;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    valid_sel  = (SELECT[5:2] == 4'b0011);
    accept     = (state_reg == ST_IDLE) && START && valid_sel && !FLUSH;
    // SELECT[1] marks the unsigned variants, SELECT[0] the remainder variants
    sel_signed = ~SELECT[1];
    sel_rem    = SELECT[0];
    a_neg      = sel_signed & DATA1[WIDTH-1];
    b_neg      = sel_signed & DATA2[WIDTH-1];
    a_abs      = a_neg ? ({WIDTH{1'b0}} - DATA1) : DATA1;
    b_abs      = b_neg ? ({WIDTH{1'b0}} - DATA2) : DATA2;
    fast       = 1'b0;
    fast_val   = '0;
    if (DATA2 == '0) begin
      fast     = 1'b1;
      fast_val = sel_rem ? DATA1 : {WIDTH{1'b1}};
    end else if (sel_signed && (DATA1 == MIN_NEG) && (&DATA2)) begin
      fast     = 1'b1;
      fast_val = sel_rem ? '0 : MIN_NEG;
    end
    rem_sh    = {rem_reg, quo_reg[WIDTH-1]};
    diff      = {1'b0, rem_sh} - {2'b00, dvs_reg};
    trial_neg = diff[WIDTH+1];
    quo_fix   = (op_signed_reg && (neg1_reg ^ neg2_reg)) ? ({WIDTH{1'b0}} - quo_reg) : quo_reg;
    rem_fix   = (op_signed_reg && neg1_reg) ? ({WIDTH{1'b0}} - rem_reg) : rem_reg;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= ST_IDLE;
      op_rem_reg    <= 1'b0;
      op_signed_reg <= 1'b0;
      neg1_reg      <= 1'b0;
      neg2_reg      <= 1'b0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvs_reg       <= '0;
      cnt_reg       <= '0;
      result_reg    <= '0;
    end else if (FLUSH) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            op_rem_reg    <= sel_rem;
            op_signed_reg <= sel_signed;
            neg1_reg      <= a_neg;
            neg2_reg      <= b_neg;
            rem_reg       <= '0;
            quo_reg       <= a_abs;
            dvs_reg       <= b_abs;
            cnt_reg       <= CW'(WIDTH - 1);
            if (fast) begin
              result_reg <= fast_val;
              state_reg  <= ST_DONE;
            end else begin
              state_reg <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (!trial_neg) rem_reg <= diff[WIDTH-1:0];
          else            rem_reg <= rem_sh[WIDTH-1:0];
          quo_reg <= {quo_reg[WIDTH-2:0], ~trial_neg};
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == '0) state_reg <= ST_FIX;
        end
        ST_FIX: begin
          result_reg <= op_rem_reg ? rem_fix : quo_fix;
          state_reg  <= ST_DONE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign RESULT = result_reg;
  assign BUSY   = (state_reg == ST_CALC) || (state_reg == ST_FIX);
  assign DONE   = (state_reg == ST_DONE);

endmodule

// File: tb/tb_alu_divider_seq.sv
// Directed self-checking bench for alu_divider_seq: latency, BUSY window, results, abort paths.
module tb_alu_divider_seq;

  localparam logic [5:0] OP_DIV  = 6'b001100;
  localparam logic [5:0] OP_REM  = 6'b001101;
  localparam logic [5:0] OP_DIVU = 6'b001110;
  localparam logic [5:0] OP_REMU = 6'b001111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  sel = '0;
  logic [31:0] d1 = '0;
  logic [31:0] d2 = '0;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  alu_divider_seq #(.WIDTH(32)) dut (
    .CLK(clk), .RESET(rst), .START(start), .FLUSH(flush), .SELECT(sel),
    .DATA1(d1), .DATA2(d2), .RESULT(result), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one op, counts edges to DONE and BUSY cycles, then checks the pulse drops.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input int exp_busy, input bit immediate);
    int lat;
    int busy_n;
    if (!immediate) @(negedge clk);
    sel = op; d1 = a; d2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; sel = '0; d1 = $urandom; d2 = $urandom;
    lat = 1; busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_cycles"}, busy_n, exp_busy);
    check({tag, " result"}, result, exp_res);
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    $display("op %s a=0x%08h b=0x%08h result=0x%08h latency=%0d busy=%0d", tag, a, b, result, lat, busy_n);
    @(negedge clk);
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int n_done;
    repeat (3) @(negedge clk);
    check("reset result", result, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 33, 1'b0);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34, 33, 1'b0);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 33, 1'b0);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 33, 1'b0);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 33, 1'b0);
    run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 33, 1'b0);
    run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 1'b0);
    run_op("remu_1234_0", OP_REMU, 32'h1234, 32'd0, 32'h1234, 1, 0, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1'b0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, 1'b0);
    run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 33, 1'b0);

    // flush at cycle 10 of a DIVU: previous result must survive
    @(negedge clk);
    sel = OP_DIVU; d1 = 32'd1000; d2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    check("flush result", result, 32'hFFFF_FFFF);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("flush no_done", n_done, 0);
    $display("flush result=0x%08h done_pulses=%0d", result, n_done);

    // reset at cycle 20 of a DIVU
    sel = OP_DIVU; d1 = 32'd77; d2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset result", result, 32'd0);
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    $display("midreset result=0x%08h busy=%0b done=%0b", result, busy, done);

    // START while busy is ignored
    @(negedge clk);
    sel = OP_DIVU; d1 = 32'd100; d2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    sel = OP_DIVU; d1 = 32'd9; d2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat++;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    check("busy_start latency", lat, 34);
    check("busy_start result", result, 32'd14);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("busy_start no_extra_done", n_done, 0);
    $display("busy_start result=0x%08h latency=%0d extra_done=%0d", result, lat, n_done);

    // invalid SELECT is not accepted
    sel = 6'b000000; d1 = 32'd50; d2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("badsel busy", {31'd0, busy}, 32'd0);
    check("badsel done", {31'd0, done}, 32'd0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("badsel idle", n_done, 0);
    check("badsel result", result, 32'd14);
    $display("badsel result=0x%08h activity=%0d", result, n_done);

    // back-to-back: second START in the cycle after the first DONE
    run_op("b2b_divu", OP_DIVU, 32'd1000, 32'd10, 32'd100, 34, 33, 1'b0);
    run_op("b2b_rem", OP_REM, 32'hFFFF_FFF7, 32'd4, 32'hFFFF_FFFF, 34, 33, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
